// File: rtl/cl_sim_pkg.sv
// Shared types and constants for the Camera Link Full ramp-image simulator.
// Sizes assume N_COL <= 4096 and N_ROW <= 2047.
package cl_sim_pkg;

    localparam int DN_SIZE       = 12;
    localparam int N_TAP         = 10;
    localparam int TAPS_PER_HALF = 5;
    localparam int HALF_W        = 8 * TAPS_PER_HALF;
    localparam int ROW_W         = 11;
    localparam int GRP_W         = 9;
    localparam int CNT_W         = 16;

    localparam logic [DN_SIZE-1:0] TOP_OFFSET = 12'h000;
    localparam logic [DN_SIZE-1:0] BTM_OFFSET = 12'h800;

    typedef logic [1:0] phase_t;
    localparam phase_t PHASE_LAST = 2'd2;

    typedef enum logic [2:0] {
        ST_FGAP,
        ST_FV_LEAD,
        ST_LINE,
        ST_LGAP,
        ST_FV_TRAIL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/cl_pixel_packer.sv
// Combinational packer: ten 12-bit ramp pixels of one group, sliced into the
// five port bytes carried on the given phase.
module cl_pixel_packer
    import cl_sim_pkg::*;
(
    input  logic [ROW_W-1:0]   row,
    input  logic [GRP_W-1:0]   grp,
    input  phase_t             phase,
    input  logic [DN_SIZE-1:0] offset,
    output logic [HALF_W-1:0]  taps
);

    logic [DN_SIZE-1:0]       base;
    logic [N_TAP*DN_SIZE-1:0] stream;

    always_comb begin
        // 12-bit sums wrap mod 4096 on their own.
        base   = DN_SIZE'(row) + DN_SIZE'(grp) * DN_SIZE'(N_TAP) + offset;
        stream = '0;
        for (int i = 0; i < N_TAP; i++) begin
            stream[(N_TAP-1-i)*DN_SIZE +: DN_SIZE] = base + DN_SIZE'(i);
        end
        case (phase)
            2'd0:    taps = stream[3*HALF_W-1 -: HALF_W];
            2'd1:    taps = stream[2*HALF_W-1 -: HALF_W];
            default: taps = stream[HALF_W-1:0];
        endcase
    end

endmodule

// File: rtl/cl_sim.sv
// Camera Link Full 10-tap camera simulator emitting a 12-bit ramp image.
// Define CLSIM_FRAME_LIMIT_EN to halt after N_FRAMES frames.
module cl_sim
    import cl_sim_pkg::*;
#(
    parameter int N_COL     = 1280,
    parameter int N_ROW     = 540,
    parameter int LINE_GAP  = 16,
    parameter int FV_LV_GAP = 4,
    parameter int FRAME_GAP = 64,
    parameter int N_FRAMES  = 4
) (
    input  logic       cl_z_pclk,
    input  logic       reset,
    output logic       cl_fval,
    output logic       cl_z_lval,
    output logic [7:0] cl_port_a,
    output logic [7:0] cl_port_b,
    output logic [7:0] cl_port_c,
    output logic [7:0] cl_port_d,
    output logic [7:0] cl_port_e,
    output logic [7:0] cl_port_f,
    output logic [7:0] cl_port_g,
    output logic [7:0] cl_port_h,
    output logic [7:0] cl_port_i,
    output logic [7:0] cl_port_j
);

`ifdef CLSIM_FRAME_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam int               N_GRP      = N_COL / N_TAP;
    localparam logic [CNT_W-1:0] FGAP_LAST  = CNT_W'(FRAME_GAP - 1);
    localparam logic [CNT_W-1:0] LEAD_LAST  = CNT_W'(FV_LV_GAP - 1);
    localparam logic [CNT_W-1:0] LGAP_LAST  = CNT_W'(LINE_GAP - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(N_FRAMES - 1);
    localparam logic [GRP_W-1:0] GRP_LAST   = GRP_W'(N_GRP - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(N_ROW - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    phase_t             phase_q, phase_d;
    logic [GRP_W-1:0]   grp_q, grp_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [CNT_W-1:0]   frame_q, frame_d;
    logic               fval_q, fval_d;
    logic               lval_q, lval_d;
    logic [HALF_W-1:0]  top_q, top_d, top_w;
    logic [HALF_W-1:0]  btm_q, btm_d, btm_w;

    // Packers look at next-state counters so port bytes line up with LVAL.
    cl_pixel_packer u_pack_top (
        .row    (row_d),
        .grp    (grp_d),
        .phase  (phase_d),
        .offset (TOP_OFFSET),
        .taps   (top_w)
    );

    cl_pixel_packer u_pack_btm (
        .row    (row_d),
        .grp    (grp_d),
        .phase  (phase_d),
        .offset (BTM_OFFSET),
        .taps   (btm_w)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        grp_d   = grp_q;
        row_d   = row_q;
        frame_d = frame_q;
        case (state_q)
            ST_FGAP: begin
                if (cnt_q == FGAP_LAST) begin
                    state_d = ST_FV_LEAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FV_LEAD: begin
                if (cnt_q == LEAD_LAST) begin
                    state_d = ST_LINE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LINE: begin
                if (phase_q != PHASE_LAST) begin
                    phase_d = phase_q + 1'b1;
                end else begin
                    phase_d = '0;
                    if (grp_q != GRP_LAST) begin
                        grp_d = grp_q + 1'b1;
                    end else begin
                        grp_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = ST_FV_TRAIL;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = ST_LGAP;
                        end
                    end
                end
            end
            ST_LGAP: begin
                if (cnt_q == LGAP_LAST) begin
                    state_d = ST_LINE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FV_TRAIL: begin
                if (cnt_q == LEAD_LAST) begin
                    cnt_d   = '0;
                    frame_d = frame_q + 1'b1;
                    state_d = (LIMIT_EN && frame_q == FRAME_LAST) ? ST_DONE : ST_FGAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: ;
            default: state_d = ST_FGAP;
        endcase

        fval_d = state_d inside {ST_FV_LEAD, ST_LINE, ST_LGAP, ST_FV_TRAIL};
        lval_d = (state_d == ST_LINE);
        top_d  = lval_d ? top_w : '0;
        btm_d  = lval_d ? btm_w : '0;
    end

    always_ff @(posedge cl_z_pclk) begin
        // NOTE: reset is synchronous and only sampled on the clock edge; state uses <= only.
        if (!reset) begin
            state_q <= ST_FGAP;
            cnt_q   <= '0;
            phase_q <= '0;
            grp_q   <= '0;
            row_q   <= '0;
            frame_q <= '0;
            fval_q  <= 1'b0;
            lval_q  <= 1'b0;
            top_q   <= '0;
            btm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            grp_q   <= grp_d;
            row_q   <= row_d;
            frame_q <= frame_d;
            fval_q  <= fval_d;
            lval_q  <= lval_d;
            top_q   <= top_d;
            btm_q   <= btm_d;
        end
    end

    assign cl_fval   = fval_q;
    assign cl_z_lval = lval_q;
    assign {cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e} = top_q;
    assign {cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j} = btm_q;

endmodule

// File: tb/tb_cl_sim.sv
// Directed bench for cl_sim: frame timing, packed ramp contents, 12-bit wrap,
// mid-line reset and (with CLSIM_FRAME_LIMIT_EN) the frame limit.
module tb_cl_sim;

    localparam int N_COL     = 4090;
    localparam int N_ROW     = 8;
    localparam int LINE_GAP  = 5;
    localparam int FV_LV_GAP = 4;
    localparam int FRAME_GAP = 8;
    localparam int N_FRAMES  = 2;
    localparam int LINE_CLKS = 3 * N_COL / 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic fval, lval;
    logic [7:0] pa, pb, pc, pd, pe, pf, pg, ph, pi, pj;
    logic [39:0] top_bus, btm_bus;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cl_sim #(
        .N_COL     (N_COL),
        .N_ROW     (N_ROW),
        .LINE_GAP  (LINE_GAP),
        .FV_LV_GAP (FV_LV_GAP),
        .FRAME_GAP (FRAME_GAP),
        .N_FRAMES  (N_FRAMES)
    ) dut (
        .cl_z_pclk (clk),
        .reset     (reset),
        .cl_fval   (fval),
        .cl_z_lval (lval),
        .cl_port_a (pa),
        .cl_port_b (pb),
        .cl_port_c (pc),
        .cl_port_d (pd),
        .cl_port_e (pe),
        .cl_port_f (pf),
        .cl_port_g (pg),
        .cl_port_h (ph),
        .cl_port_i (pi),
        .cl_port_j (pj)
    );

    assign top_bus = {pa, pb, pc, pd, pe};
    assign btm_bus = {pf, pg, ph, pi, pj};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Recover the DNs carried on one phase using the port alignment table.
    function automatic logic [47:0] unpack(input int k, input logic [39:0] p, input logic [7:0] e_prev);
        logic [7:0] a, b, c, d, e;
        {a, b, c, d, e} = p;
        case (k)
            0:       return {12'h000, a, b[7:4], b[3:0], c, d, e[7:4]};
            1:       return {12'h000, e_prev[3:0], a, b, c[7:4], c[3:0], d};
            default: return {e_prev, a[7:4], a[3:0], b, c, d[7:4], d[3:0], e};
        endcase
    endfunction

    function automatic logic [47:0] ramp(input int k, input int r, input int g, input int off);
        logic [47:0] v;
        int n;
        int first;
        v     = '0;
        n     = (k == 2) ? 4 : 3;
        first = 3 * k;
        for (int i = 0; i < n; i++) begin
            v[12*(n-1-i) +: 12] = 12'((r + 10 * g + first + i + off) % 4096);
        end
        return v;
    endfunction

    // Entered on the first FVAL-low sample of a gap; runs to the first LVAL sample.
    task automatic expect_frame_start();
        int low;
        int lead;
        low  = 0;
        lead = 0;
        for (int n = 0; n < 1000 && !fval; n++) begin
            low++;
            @(negedge clk);
        end
        check("fval_low_clks", low, FRAME_GAP);
        for (int n = 0; n < 1000 && fval && !lval; n++) begin
            lead++;
            @(negedge clk);
        end
        check("fv_lead_clks", lead, FV_LV_GAP);
        check("first_lval", lval, 1);
        check("first_top_ports", top_bus, 40'h00_00_01_00_20);
        check("first_btm_ports", btm_bus, 40'h80_08_01_80_28);
    endtask

    // Entered on the first LVAL sample of a frame; stops early at row 3 phase 1 if asked.
    task automatic scan_frame(input bit stop_mid);
        int r, cyc, gap, k, g;
        bit prev_lval;
        logic [7:0] e_top, e_btm;
        logic [47:0] dn_top, dn_btm;
        r = 0; cyc = 0; gap = 0;
        prev_lval = 1'b1;
        e_top = '0; e_btm = '0;
        for (int n = 0; n < 20000 && fval; n++) begin
            if (lval) begin
                if (!prev_lval) begin
                    check("line_gap_clks", gap, LINE_GAP);
                    r++;
                    cyc = 0;
                end
                k = cyc % 3;
                g = cyc / 3;
                if (stop_mid && r == 3 && k == 1) return;
                dn_top = unpack(k, top_bus, e_top);
                dn_btm = unpack(k, btm_bus, e_btm);
                check("dn_top", dn_top, ramp(k, r, g, 0));
                check("dn_btm", dn_btm, ramp(k, r, g, 2048));
                if (r == N_ROW - 1 && g == N_COL / 10 - 1 && k == 2)
                    check("top_wrap_4096", dn_top[11:0], 12'h000);
                e_top = top_bus[7:0];
                e_btm = btm_bus[7:0];
                cyc++;
            end else begin
                if (prev_lval) begin
                    check("lval_len_clks", cyc, LINE_CLKS);
                    gap = 0;
                end
                check("idle_ports_zero", {top_bus, btm_bus}, 80'h0);
                gap++;
            end
            prev_lval = lval;
            @(negedge clk);
        end
        check("frame_ended", fval, 0);
        check("fv_trail_clks", gap, FV_LV_GAP);
        check("rows_per_frame", r + 1, N_ROW);
    endtask

    initial begin
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_fval", fval, 0);
        check("rst_lval", lval, 0);
        check("rst_ports", {top_bus, btm_bus}, 80'h0);
        reset = 1'b1;

        expect_frame_start();
        scan_frame(1'b0);
        expect_frame_start();
        scan_frame(1'b1);
        check("mid_line_lval", lval, 1);

        reset = 1'b0;
        @(negedge clk);
        check("midrst_fval", fval, 0);
        check("midrst_lval", lval, 0);
        check("midrst_ports", {top_bus, btm_bus}, 80'h0);
        reset = 1'b1;
        expect_frame_start();

`ifdef CLSIM_FRAME_LIMIT_EN
        begin
            int rises;
            int quiet;
            bit prev_fval;
            rises = 1;
            quiet = 0;
            prev_fval = 1'b1;
            for (int n = 0; n < 25000; n++) begin
                @(negedge clk);
                if (fval && !prev_fval) rises++;
                prev_fval = fval;
                if (fval || lval || top_bus != 0 || btm_bus != 0) quiet = 0;
                else quiet++;
            end
            check("frame_pulses", rises, N_FRAMES);
            check("halt_quiet", quiet >= 10 * FRAME_GAP, 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
